// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial receiver, one bit per clock.
// Detects a start bit (SIN low in IDLE) and shifts in DATA_BITS data bits
// LSB-first. It then checks an optional parity bit and the stop bit.
// A good frame updates DOUT and PERR together with a one-cycle VALID strobe.
// A low stop bit raises a one-cycle FERR strobe; the FSM then waits for the
// line to return high before it looks for the next start bit.
//
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   SIN   : serial line, idles high
//   DOUT  : last word received without a framing error
//   VALID : one-cycle strobe, DOUT/PERR updated this cycle
//   PERR  : parity mismatch of the strobed word (held between strobes)
//   FERR  : one-cycle strobe, stop bit sampled low
//   BUSY  : FSM not in IDLE
module serial_frame_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SIN,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 VALID,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 BUSY
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!SIN) begin
          state_d   = DATA;
          cnt_d     = '0;
          shift_d   = '0;
          par_err_d = 1'b0;
        end
      end

      DATA: begin
        // New bit enters at the MSB end, so the first bit ends up in bit 0.
        // Written as shift/or so it also elaborates for DATA_BITS == 1.
        shift_d = (shift_q >> 1) | (DATA_BITS'(SIN) << (DATA_BITS - 1));
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
          state_d = PARITY_EN ? PARITY : STOP;
        end
      end

      PARITY: begin
        par_err_d = (((^shift_q) ^ SIN) != PARITY_ODD);
        state_d   = STOP;
      end

      STOP: begin
        if (SIN) begin
          dout_d  = shift_q;
          valid_d = 1'b1;
          perr_d  = PARITY_EN ? par_err_q : 1'b0;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        // A stuck-low line must not be read as a string of start bits.
        if (SIN) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign PERR  = perr_q;
  assign FERR  = ferr_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with default parameters.
// Expected strobes are queued when a frame's start bit is driven and are
// popped when VALID or FERR shows up, including the cycle it should occur in.
module tb_serial_frame_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SIN = 1'b1;
  logic [7:0] DOUT;
  logic       VALID;
  logic       PERR;
  logic       FERR;
  logic       BUSY;

  serial_frame_rx #(
    .DATA_BITS (8),
    .PARITY_EN (1'b1),
    .PARITY_ODD(1'b0)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .SIN  (SIN),
    .DOUT (DOUT),
    .VALID(VALID),
    .PERR (PERR),
    .FERR (FERR),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       v;
    logic       f;
    logic [7:0] dout;
    logic       perr;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_perr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check any strobe against the scoreboard, then drive the next bit.
  task automatic tick(input logic b);
    exp_t e;
    @(negedge CLK);
    if (VALID || FERR) begin
      chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("valid", 32'(VALID), 32'(e.v));
        chk("ferr", 32'(FERR), 32'(e.f));
        chk("dout", 32'(DOUT), 32'(e.dout));
        if (e.v) chk("perr", 32'(PERR), 32'(e.perr));
        chk("strobe_cycle", 32'(cyc), 32'(e.due));
      end
    end
    SIN = b;
  endtask

  // Drive start, 8 data bits LSB-first, parity bit, stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    tick(1'b0);
    e.due = cyc + 11;
    if (stop) begin
      e.v       = 1'b1;
      e.f       = 1'b0;
      e.perr    = (^d) ^ par;
      e.dout    = d;
      last_dout = d;
      last_perr = e.perr;
    end else begin
      e.v    = 1'b0;
      e.f    = 1'b1;
      e.perr = last_perr;
      e.dout = last_dout;
    end
    sb.push_back(e);
    for (int i = 0; i < 8; i++) tick(d[i]);
    tick(par);
    tick(stop);
  endtask

  initial begin
    logic [7:0] d5a;

    // Reset with the line idle, then 20 idle cycles.
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      chk("idle_dout", 32'(DOUT), 32'h0);
      chk("idle_valid", 32'(VALID), 32'h0);
      chk("idle_ferr", 32'(FERR), 32'h0);
      chk("idle_perr", 32'(PERR), 32'h0);
      chk("idle_busy", 32'(BUSY), 32'h0);
    end

    // 0xA5, correct even parity.
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(1'b1);
    chk("busy_after_a5", 32'(BUSY), 32'h0);
    tick(1'b1);

    // 0xA5 with parity bit flipped.
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(1'b1);
    tick(1'b1);

    // 0x3C with a low stop bit, line held low 5 more cycles.
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      chk("busy_wait_idle", 32'(BUSY), 32'h1);
    end
    tick(1'b1);
    chk("busy_still_wait", 32'(BUSY), 32'h1);
    tick(1'b1);
    chk("busy_released", 32'(BUSY), 32'h0);
    chk("dout_held", 32'(DOUT), 32'hA5);

    // Back-to-back frames, no gap.
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    tick(1'b1);
    tick(1'b1);

    // Reset while data bit 4 of 0x5A is on the line.
    d5a = 8'h5A;
    tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(d5a[i]);
      if (i == 1) chk("busy_mid_frame", 32'(BUSY), 32'h1);
    end
    tick(d5a[4]);
    RST = 1'b1;
    tick(1'b1);
    RST = 1'b0;
    last_dout = 8'h00;
    last_perr = 1'b0;
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_dout", 32'(DOUT), 32'h0);
    chk("rst_valid", 32'(VALID), 32'h0);
    for (int i = 0; i < 12; i++) tick(1'b1);

    send_frame(8'h81, 1'b0, 1'b1);

    // Drain the scoreboard with a bounded wait, then watch for stray strobes.
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick(1'b1);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    for (int i = 0; i < 10; i++) tick(1'b1);
    chk("final_dout", 32'(DOUT), 32'h81);
    chk("final_busy", 32'(BUSY), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver directly downstream of the D flip-flop stage. It consumes the registered bit stream that stage produces, at one bit per clock. It detects a start bit, shifts in a fixed-width data word LSB-first, checks optional parity and the stop bit, and presents the assembled word with a one-cycle valid strobe plus error flags.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, legal range 1..16.
- PARITY_EN, 1: 1 means a parity bit follows the data; 0 means no parity bit.
- PARITY_ODD, 0: 0 selects even parity; 1 selects odd parity.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset. There is one clock, and reset is sampled on the CLK rising edge.
- SIN  input  1  serial line, fed from the flip-flop stage's Q output; idles high.
- DOUT  output  DATA_BITS  last word received without a framing error.
- VALID  output  1  one-cycle strobe; DOUT, PERR updated this cycle.
- PERR  output  1  parity mismatch on the word currently strobed; meaningful only with VALID.
- FERR  output  1  one-cycle strobe when the stop bit is sampled low.
- BUSY  output  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - SIN=0 sampled: go to DATA, clear bit counter and shift register.
  - SIN=1: stay in IDLE.
- DATA:
  - Each cycle, shift SIN into the shift register MSB end, so after DATA_BITS shifts bit 0 holds the first data bit (LSB-first).
  - After the DATA_BITS-th bit: go to PARITY if PARITY_EN, else go to STOP.
- PARITY:
  - Sample SIN as the parity bit.
  - Mismatch is defined as (XOR of data bits XOR parity bit) != PARITY_ODD.
  - Latch the mismatch result internally, then go to STOP.
- STOP:
  - SIN=1: load DOUT from the shift register, assert VALID, drive PERR with the latched mismatch (0 when PARITY_EN=0), go to IDLE.
  - SIN=0: assert FERR, leave DOUT unchanged, keep VALID=0, go to WAIT_IDLE.
- WAIT_IDLE: stay until SIN=1 is sampled, then go to IDLE. This prevents a stuck-low line from being read as repeated start bits.
- Reset values: DOUT=0, VALID=0, PERR=0, FERR=0, BUSY=0, FSM=IDLE, counter=0.
- RST is asserted mid-frame:
  - The frame is abandoned and no VALID or FERR is produced.
  - The FSM returns to IDLE on that edge.
- Counter width is clog2(DATA_BITS+1). The counter never wraps, because it is cleared on entry to DATA.

## Timing
- Let edge k be the edge that samples the start bit (SIN=0) in IDLE.
- Data bits are sampled at edges k+1 .. k+DATA_BITS.
- With parity (P = 1 if PARITY_EN, else 0):
  - The parity bit is sampled at edge k+DATA_BITS+1.
  - The stop bit is sampled at edge k+DATA_BITS+1+P.
- VALID or FERR is registered high for exactly the one cycle following the stop-sample edge. Defaults: 11 cycles after the start edge.
- Frame length is 1+DATA_BITS+P+1 bits.
- Back-to-back frames: the next start bit may be sampled at the edge immediately after the stop-sample edge. There is no dead cycle, so frames run continuously at full rate.
- BUSY:
  - Rises in the cycle after edge k.
  - Falls in the cycle after the stop-sample edge, coinciding with VALID.
  - After a framing error, falls in the cycle after SIN=1 is sampled in WAIT_IDLE.
- PERR is valid only while VALID=1; outside VALID it holds its last value.
- DOUT holds its value between VALID strobes.

## Test plan
- Reset with SIN=1, then hold 20 cycles idle high -> all outputs 0, BUSY=0, no strobes.
- Defaults, SIN stream 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB-first, even parity 0, stop) -> VALID for one cycle 11 cycles after start edge; DOUT=0xA5; PERR=0; FERR=0.
- Same frame with the parity bit flipped to 1 -> VALID=1, DOUT=0xA5, PERR=1.
- Frame 0x3C with stop bit 0, then SIN held low 5 cycles, then high -> FERR for one cycle, no VALID, DOUT keeps the prior 0xA5, BUSY stays 1 until SIN returns high.
- Back-to-back frames 0x3C then 0xFF (even parity bits 0 and 0), no idle gap -> two VALID strobes 11 cycles apart, DOUT=0x3C then 0xFF, PERR=0 both.
- RST pulsed at data bit 4 of a 0x5A frame, line returns to idle -> no VALID/FERR, BUSY=0 after reset edge; the next clean 0x81 frame is received correctly.
